// File: rtl/sumsq_serial.sv
// Serial X*X + Y*Y with a shift-add multiplier, saturated to OW bits, valid/ready on both sides.
// Define SUMSQ_OVF_FLAG_EN to add the OVF output flagging a saturated result.
module sumsq_serial #(
    parameter int W  = 4,
    parameter int OW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [W-1:0]  X,
    input  logic [W-1:0]  Y,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [OW-1:0] O,
    output logic          OUT_VALID,
    input  logic          OUT_READY
`ifdef SUMSQ_OVF_FLAG_EN
    ,
    output logic          OVF
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULX = 2'd1,
        MULY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [OW:0]     acc_q, acc_d;
    logic [OW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplr_q, mplr_d;
    logic [W-1:0]    yh_q, yh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   o_q, o_d;
`ifdef SUMSQ_OVF_FLAG_EN
    logic            ovf_q, ovf_d;
`endif

    logic [OW:0]     addend;
    logic [OW:0]     acc_step;

    // The sum never exceeds OW+1 bits, so only the carry bit decides saturation.
    function automatic logic [OW-1:0] sat_sum(input logic [OW:0] v);
        return v[OW] ? {OW{1'b1}} : v[OW-1:0];
    endfunction

    assign addend   = mplr_q[0] ? {1'b0, mcand_q} : '0;
    assign acc_step = acc_q + addend;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        yh_d    = yh_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
`ifdef SUMSQ_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    mcand_d = {{(OW-W){1'b0}}, X};
                    mplr_d  = X;
                    yh_d    = Y;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef SUMSQ_OVF_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = MULX;
                end
            end
            MULX: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Reload the multiplier pair with Y; ACC keeps X*X.
                    mcand_d = {{(OW-W){1'b0}}, yh_q};
                    mplr_d  = yh_q;
                    cnt_d   = '0;
                    state_d = MULY;
                end
            end
            MULY: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    o_d     = sat_sum(acc_step);
`ifdef SUMSQ_OVF_FLAG_EN
                    ovf_d   = acc_step[OW];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            yh_q    <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
`ifdef SUMSQ_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            yh_q    <= yh_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
`ifdef SUMSQ_OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake flags decode the registered state only.
    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign O         = o_q;
`ifdef SUMSQ_OVF_FLAG_EN
    assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_sumsq_serial.sv
// Directed bench for sumsq_serial: latency, saturation, back-pressure, async abort, back-to-back.
// Checks OVF as well when SUMSQ_OVF_FLAG_EN is defined.
module tb_sumsq_serial;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] X, Y;
    logic       IN_VALID, IN_READY;
    logic [7:0] O;
    logic       OUT_VALID, OUT_READY;
`ifdef SUMSQ_OVF_FLAG_EN
    logic       OVF;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sumsq_serial #(.W(4), .OW(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .X         (X),
        .Y         (Y),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .O         (O),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
`ifdef SUMSQ_OVF_FLAG_EN
        ,
        .OVF       (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!IN_READY && k < 40) begin
            @(posedge CLK); #1;
            k++;
        end
        chk({tag, "_rdy"}, IN_READY, 1);
    endtask

    task automatic check_ovf(input string tag, input logic exp_ovf);
`ifdef SUMSQ_OVF_FLAG_EN
        chk({tag, "_ovf"}, OVF, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("note %s: unknown overflow expectation", tag);
`endif
    endtask

    // Accept one vector, check latency/result; if rdy, also check the handshake back to IDLE.
    task automatic run_vec(input string tag, input logic [3:0] x, input logic [3:0] y,
                           input logic [7:0] exp_o, input logic exp_ovf, input logic rdy);
        int   k;
        logic ir_low;
        wait_ready(tag);
        X = x; Y = y; IN_VALID = 1'b1; OUT_READY = rdy;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; X = ~x; Y = ~y;
        ir_low = 1'b1;
        k = 0;
        while (!OUT_VALID && k < 20) begin
            if (IN_READY) ir_low = 1'b0;
            @(posedge CLK); #1;
            k++;
        end
        chk({tag, "_lat"}, k, 8);
        chk({tag, "_irdy_low"}, ir_low, 1);
        chk({tag, "_o"}, O, exp_o);
        check_ovf(tag, exp_ovf);
        if (rdy) begin
            @(posedge CLK); #1;
            chk({tag, "_vld_drop"}, OUT_VALID, 0);
            chk({tag, "_idle"}, IN_READY, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] vx [3];
        logic [3:0] vy [3];
        logic [7:0] vo [3];
        int e, nacc, nout, last_acc, last_hs;
        logic pr, pv;
        logic [7:0] po;

        RST_N = 1'b0; X = '0; Y = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        #3;
        chk("rst_ovld", OUT_VALID, 0);
        chk("rst_irdy", IN_READY, 1);
        chk("rst_o", O, 0);
        check_ovf("rst", 1'b0);
        #20;
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        run_vec("v3_4",   4'd3,  4'd4,  8'd25,  1'b0, 1'b1);
        run_vec("v11_10", 4'd11, 4'd10, 8'd221, 1'b0, 1'b1);
        run_vec("v12_11", 4'd12, 4'd11, 8'd255, 1'b1, 1'b1);
        run_vec("v15_15", 4'd15, 4'd15, 8'd255, 1'b1, 1'b1);
        run_vec("v0_0",   4'd0,  4'd0,  8'd0,   1'b0, 1'b1);
        run_vec("v15_0",  4'd15, 4'd0,  8'd225, 1'b0, 1'b1);

        // Back-pressure: result held while new requests are offered and ignored.
        run_vec("bp", 4'd5, 4'd2, 8'd29, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1; X = 4'd1; Y = 4'd1;
            @(posedge CLK); #1;
            chk("bp_hold_o", O, 29);
            chk("bp_hold_vld", OUT_VALID, 1);
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("bp_release_vld", OUT_VALID, 0);
        chk("bp_release_irdy", IN_READY, 1);
        @(posedge CLK); #1;
        chk("bp_still_idle", IN_READY, 1);

        // Asynchronous abort in the middle of the Y multiply.
        wait_ready("abort");
        X = 4'd9; Y = 4'd9; IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (6) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_ovld", OUT_VALID, 0);
        chk("abort_o", O, 0);
        chk("abort_irdy", IN_READY, 1);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("abort_no_result", OUT_VALID, 0);
        run_vec("v2_3", 4'd2, 4'd3, 8'd13, 1'b0, 1'b1);

        // Back-to-back with IN_VALID and OUT_READY held high.
        vx[0] = 4'd1; vy[0] = 4'd1; vo[0] = 8'd2;
        vx[1] = 4'd7; vy[1] = 4'd7; vo[1] = 8'd98;
        vx[2] = 4'd8; vy[2] = 4'd8; vo[2] = 8'd128;
        e = 0; nacc = 0; nout = 0; last_acc = -1; last_hs = -1;
        X = vx[0]; Y = vy[0]; IN_VALID = 1'b1; OUT_READY = 1'b1;
        while (nout < 3 && e < 60) begin
            pr = IN_READY; pv = OUT_VALID; po = O;
            @(posedge CLK); #1;
            e++;
            if (pv) begin
                chk("b2b_o", po, vo[nout]);
                nout++;
                last_hs = e;
            end
            if (pr) begin
                if (last_hs >= 0) chk("b2b_accept_after_hs", e - last_hs, 1);
                if (last_acc >= 0) chk("b2b_period", e - last_acc, 10);
                last_acc = e;
                nacc++;
                if (nacc < 3) begin
                    X = vx[nacc]; Y = vy[nacc];
                end
            end
        end
        chk("b2b_outputs", nout, 3);
        IN_VALID = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
